// File: rtl/multi_usage_counter_if.sv
// Bus bundle for multi_usage_counter: window control, observed signals and snapshot readback.
// The master side drives the window/control inputs; the counter sits on the slave side.
interface multi_usage_counter_if #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 16
);
  localparam int RC_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                     counter_reset;
  logic [NUM_CHANNELS-1:0]  observable_pulse;
  logic                     sample_enable;
  logic [RC_W-1:0]          read_channel;
  logic [COUNTER_WIDTH-1:0] counter_out;
  logic [COUNTER_WIDTH-1:0] window_out;
  logic                     snapshot_valid;
  logic [NUM_CHANNELS-1:0]  overflow_flags;

  modport master (
    output counter_reset, observable_pulse, sample_enable, read_channel,
    input  counter_out, window_out, snapshot_valid, overflow_flags
  );

  modport slave (
    input  counter_reset, observable_pulse, sample_enable, read_channel,
    output counter_out, window_out, snapshot_valid, overflow_flags
  );
endinterface

// File: rtl/multi_usage_counter.sv
// Per-channel activity counter over sample_enable windows, snapshotted on window close.
// Optional sticky saturation flags: define USAGE_COUNTER_OVERFLOW_EN.
module multi_usage_counter #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int EDGE_MODE     = 0
) (
  input logic                  sysclk,
  input logic                  sysreset,
  multi_usage_counter_if.slave bus
);
  typedef logic [COUNTER_WIDTH-1:0] cnt_t;
  typedef enum logic {IDLE, SAMPLING} state_t;

  localparam cnt_t CNT_MAX = '1;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + cnt_t'(1);
  endfunction

  state_t                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] obs_q;
  logic [NUM_CHANNELS-1:0] evt;
  logic                    close;
  cnt_t                    acc_q  [NUM_CHANNELS];
  cnt_t                    acc_d  [NUM_CHANNELS];
  cnt_t                    snap_q [NUM_CHANNELS];
  cnt_t                    snap_d [NUM_CHANNELS];
  cnt_t                    win_q, win_d;
  cnt_t                    wsnap_q, wsnap_d;
  cnt_t                    cout_q, cout_d;
  logic                    valid_q, valid_d;

  always_comb begin
    state_d = bus.sample_enable ? SAMPLING : IDLE;
    close   = (state_q == SAMPLING) && !bus.sample_enable;
    if (EDGE_MODE != 0) evt = bus.observable_pulse & ~obs_q;
    else                evt = bus.observable_pulse;
  end

  // Accumulate / close / clear
  always_comb begin
    acc_d   = acc_q;
    snap_d  = snap_q;
    win_d   = win_q;
    wsnap_d = wsnap_q;
    valid_d = 1'b0;
    if (bus.counter_reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        acc_d[ch]  = '0;
        snap_d[ch] = '0;
      end
      win_d   = '0;
      wsnap_d = '0;
    end else if (close) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        snap_d[ch] = acc_q[ch];
        acc_d[ch]  = '0;
      end
      wsnap_d = win_q;
      win_d   = '0;
      valid_d = 1'b1;
    end else if (bus.sample_enable) begin
      win_d = sat_inc(win_q);
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (evt[ch]) acc_d[ch] = sat_inc(acc_q[ch]);
      end
    end
  end

  // Readback mux works off the next snapshot so counter_out lines up with snapshot_valid
  always_comb begin
    cout_d = '0;
    if (32'(bus.read_channel) < NUM_CHANNELS) cout_d = snap_d[bus.read_channel];
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q <= IDLE;
      obs_q   <= '0;
      win_q   <= '0;
      wsnap_q <= '0;
      cout_q  <= '0;
      valid_q <= 1'b0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        acc_q[ch]  <= '0;
        snap_q[ch] <= '0;
      end
    end else begin
      state_q <= state_d;
      obs_q   <= bus.observable_pulse;
      win_q   <= win_d;
      wsnap_q <= wsnap_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        acc_q[ch]  <= acc_d[ch];
        snap_q[ch] <= snap_d[ch];
      end
    end
  end

`ifdef USAGE_COUNTER_OVERFLOW_EN
  logic [NUM_CHANNELS-1:0] ovf_hit;
  logic [NUM_CHANNELS-1:0] ovf_q;

  // A flag sets when a qualifying event arrives with the accumulator already pinned
  always_comb begin
    ovf_hit = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      ovf_hit[ch] = !bus.counter_reset && !close && bus.sample_enable &&
                    evt[ch] && (acc_q[ch] == CNT_MAX);
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset)               ovf_q <= '0;
    else if (bus.counter_reset) ovf_q <= '0;
    else                        ovf_q <= ovf_q | ovf_hit;
  end

  assign bus.overflow_flags = ovf_q;
`else
  assign bus.overflow_flags = '0;
`endif

  assign bus.counter_out    = cout_q;
  assign bus.window_out     = wsnap_q;
  assign bus.snapshot_valid = valid_q;
endmodule

// File: tb/tb_multi_usage_counter.sv
// Bench for multi_usage_counter: four configurations share one stimulus stream and a
// window-level reference model; directed sequences cover the documented corner cases.
module tb_multi_usage_counter;
  localparam int NI = 4;
`ifdef USAGE_COUNTER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // Instance configurations: A(4ch,16b,level) B(4ch,16b,edge) C(4ch,4b,level) D(3ch,8b,level)
  int n_p [NI] = '{4, 4, 4, 3};
  int w_p [NI] = '{16, 16, 4, 8};
  int e_p [NI] = '{0, 1, 0, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] obs;
  logic       en, cr;
  logic [1:0] rc;

  always #5 clk = ~clk;

  multi_usage_counter_if #(.NUM_CHANNELS(4), .COUNTER_WIDTH(16)) if_a ();
  multi_usage_counter_if #(.NUM_CHANNELS(4), .COUNTER_WIDTH(16)) if_b ();
  multi_usage_counter_if #(.NUM_CHANNELS(4), .COUNTER_WIDTH(4))  if_c ();
  multi_usage_counter_if #(.NUM_CHANNELS(3), .COUNTER_WIDTH(8))  if_d ();

  assign if_a.counter_reset = cr;  assign if_a.sample_enable = en;
  assign if_a.observable_pulse = obs; assign if_a.read_channel = rc;
  assign if_b.counter_reset = cr;  assign if_b.sample_enable = en;
  assign if_b.observable_pulse = obs; assign if_b.read_channel = rc;
  assign if_c.counter_reset = cr;  assign if_c.sample_enable = en;
  assign if_c.observable_pulse = obs; assign if_c.read_channel = rc;
  assign if_d.counter_reset = cr;  assign if_d.sample_enable = en;
  assign if_d.observable_pulse = obs[2:0]; assign if_d.read_channel = rc;

  multi_usage_counter #(.NUM_CHANNELS(4), .COUNTER_WIDTH(16), .EDGE_MODE(0))
    u_a (.sysclk(clk), .sysreset(rst), .bus(if_a.slave));
  multi_usage_counter #(.NUM_CHANNELS(4), .COUNTER_WIDTH(16), .EDGE_MODE(1))
    u_b (.sysclk(clk), .sysreset(rst), .bus(if_b.slave));
  multi_usage_counter #(.NUM_CHANNELS(4), .COUNTER_WIDTH(4), .EDGE_MODE(0))
    u_c (.sysclk(clk), .sysreset(rst), .bus(if_c.slave));
  multi_usage_counter #(.NUM_CHANNELS(3), .COUNTER_WIDTH(8), .EDGE_MODE(0))
    u_d (.sysclk(clk), .sysreset(rst), .bus(if_d.slave));

  logic [15:0] co [NI];
  logic [15:0] wo [NI];
  logic        sv [NI];
  logic [3:0]  of [NI];

  assign co[0] = if_a.counter_out;           assign wo[0] = if_a.window_out;
  assign co[1] = if_b.counter_out;           assign wo[1] = if_b.window_out;
  assign co[2] = {12'b0, if_c.counter_out};  assign wo[2] = {12'b0, if_c.window_out};
  assign co[3] = {8'b0, if_d.counter_out};   assign wo[3] = {8'b0, if_d.window_out};
  assign sv[0] = if_a.snapshot_valid;  assign of[0] = if_a.overflow_flags;
  assign sv[1] = if_b.snapshot_valid;  assign of[1] = if_b.overflow_flags;
  assign sv[2] = if_c.snapshot_valid;  assign of[2] = if_c.overflow_flags;
  assign sv[3] = if_d.snapshot_valid;  assign of[3] = {1'b0, if_d.overflow_flags};

  // Reference model: the open window is a record of (obs, previous obs) per counted cycle
  logic [3:0] q_obs  [$];
  logic [3:0] q_prev [$];
  int         snap_m  [NI][4];
  int         wsnap_m [NI];
  bit [3:0]   ovf_m   [NI];
  bit         valid_m;
  bit         prev_en;
  logic [3:0] prev_obs;

  int checks = 0;
  int failures = 0;

  function automatic int maxv(int i);
    return (1 << w_p[i]) - 1;
  endfunction

  function automatic int raw_count(int i, int ch);
    int cnt = 0;
    for (int k = 0; k < q_obs.size(); k++) begin
      if (e_p[i] != 0) cnt += (q_obs[k][ch] && !q_prev[k][ch]) ? 1 : 0;
      else             cnt += q_obs[k][ch] ? 1 : 0;
    end
    return cnt;
  endfunction

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_clear_all();
    q_obs.delete(); q_prev.delete();
    for (int i = 0; i < NI; i++) begin
      wsnap_m[i] = 0; ovf_m[i] = '0;
      for (int ch = 0; ch < 4; ch++) snap_m[i][ch] = 0;
    end
  endfunction

  function automatic void model_update();
    valid_m = 1'b0;
    if (rst) begin
      model_clear_all();
      prev_en = 1'b0; prev_obs = '0;
    end else begin
      if (cr) begin
        model_clear_all();
      end else if (prev_en && !en) begin
        for (int i = 0; i < NI; i++) begin
          for (int ch = 0; ch < n_p[i]; ch++) snap_m[i][ch] = min2(raw_count(i, ch), maxv(i));
          wsnap_m[i] = min2(q_obs.size(), maxv(i));
        end
        valid_m = 1'b1;
        q_obs.delete(); q_prev.delete();
      end else if (en) begin
        q_obs.push_back(obs); q_prev.push_back(prev_obs);
        for (int i = 0; i < NI; i++)
          for (int ch = 0; ch < n_p[i]; ch++)
            if (raw_count(i, ch) > maxv(i)) ovf_m[i][ch] = 1'b1;
      end
      prev_en = en; prev_obs = obs;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int ec;
      int eo;
      ec = (int'(rc) < n_p[i]) ? snap_m[i][rc] : 0;
      eo = OVF_EN ? int'(ovf_m[i]) : 0;
      chk($sformatf("model_co[%0d]", i), int'(co[i]), ec);
      chk($sformatf("model_wo[%0d]", i), int'(wo[i]), wsnap_m[i]);
      chk($sformatf("model_sv[%0d]", i), int'(sv[i]), int'(valid_m));
      chk($sformatf("model_of[%0d]", i), int'(of[i]), eo);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  typedef struct {
    int         inst;
    logic [1:0] rc;
    int         exp_co;
    int         exp_wo;
  } rd_vec_t;

  rd_vec_t rtab [6];

  initial begin
    rtab[0] = '{inst: 0, rc: 2'd0, exp_co: 3,  exp_wo: 10};
    rtab[1] = '{inst: 0, rc: 2'd1, exp_co: 10, exp_wo: 10};
    rtab[2] = '{inst: 0, rc: 2'd2, exp_co: 0,  exp_wo: 10};
    rtab[3] = '{inst: 0, rc: 2'd3, exp_co: 0,  exp_wo: 10};
    rtab[4] = '{inst: 3, rc: 2'd3, exp_co: 0,  exp_wo: 10};
    rtab[5] = '{inst: 3, rc: 2'd1, exp_co: 10, exp_wo: 10};

    obs = '0; en = 1'b0; cr = 1'b0; rc = '0;
    prev_en = 1'b0; prev_obs = '0; valid_m = 1'b0;
    model_clear_all();
    rst = 1'b0;
    #1 rst = 1'b1;
    step(); step();
    chk("reset_co", int'(co[0]), 0);
    chk("reset_wo", int'(wo[0]), 0);
    rst = 1'b0;

    // Reset mid-window with toggling inputs
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin obs = (i % 2) ? 4'hF : 4'h0; step(); end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin obs = (i % 2) ? 4'hF : 4'h0; step(); end
    chk("midrst_co", int'(co[0]), 0);
    chk("midrst_wo", int'(wo[0]), 0);
    chk("midrst_sv", int'(sv[0]), 0);
    rst = 1'b0; en = 1'b0; obs = '0;
    step(); chk("postrst_sv0", int'(sv[0]), 0);
    step(); chk("postrst_sv1", int'(sv[0]), 0);

    // Level mode: 10-cycle window, ch0 high 3 cycles, ch1 constant
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin obs = {2'b00, 1'b1, (i < 3)}; step(); end
    en = 1'b0; obs = '0; step();
    chk("lvl_sv", int'(sv[0]), 1);
    chk("lvl_co", int'(co[0]), 3);
    chk("lvl_wo", int'(wo[0]), 10);
    step(); chk("lvl_sv_pulse", int'(sv[0]), 0);
    for (int k = 0; k < 6; k++) begin
      rc = rtab[k].rc;
      step();
      chk($sformatf("tab%0d_co", k), int'(co[rtab[k].inst]), rtab[k].exp_co);
      chk($sformatf("tab%0d_wo", k), int'(wo[rtab[k].inst]), rtab[k].exp_wo);
    end

    // Edge mode: 3 pulses in a 15-cycle window, 3 more while idle
    rc = 2'd0; obs = '0; step(); step();
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin obs = {3'b000, (i == 2 || i == 6 || i == 10)}; step(); end
    en = 1'b0; obs = '0; step();
    chk("edge_co", int'(co[1]), 3);
    chk("edge_wo", int'(wo[1]), 15);
    chk("edge_sv", int'(sv[1]), 1);
    for (int i = 0; i < 6; i++) begin obs = {3'b000, 1'(i % 2)}; step(); end
    chk("edge_idle_co", int'(co[1]), 3);
    obs = '0; en = 1'b1; step(); step();
    en = 1'b0; step();
    chk("edge_next_co", int'(co[1]), 0);
    chk("edge_next_wo", int'(wo[1]), 2);

    // Saturation on the 4-bit instance, then a clean window keeps the sticky flag
    en = 1'b1; obs = 4'b0001;
    for (int i = 0; i < 20; i++) step();
    en = 1'b0; obs = '0; step();
    chk("sat_co", int'(co[2]), 15);
    chk("sat_wo", int'(wo[2]), 15);
    chk("sat_of", int'(of[2][0]), int'(OVF_EN));
    chk("wide_co", int'(co[0]), 20);
    en = 1'b1; obs = 4'b0010;
    for (int i = 0; i < 3; i++) step();
    en = 1'b0; obs = '0; step();
    chk("clean_co", int'(co[2]), 0);
    chk("clean_wo", int'(wo[2]), 3);
    chk("clean_of", int'(of[2][0]), int'(OVF_EN));

    // counter_reset on the close cycle
    rc = 2'd1; step();
    chk("pre_cr_co", int'(co[0]), 3);
    en = 1'b1; obs = 4'b0010;
    for (int i = 0; i < 4; i++) step();
    en = 1'b0; cr = 1'b1; obs = '0; step();
    chk("cr_sv", int'(sv[0]), 0);
    chk("cr_co", int'(co[0]), 0);
    chk("cr_wo", int'(wo[0]), 0);
    chk("cr_of", int'(of[2]), 0);
    cr = 1'b0; step();
    chk("cr_sv_after", int'(sv[0]), 0);

    // 1-cycle window then 5-cycle window, one idle cycle apart
    rc = 2'd0; obs = 4'b0001; step();
    en = 1'b1; step();
    en = 1'b0; step();
    chk("w1_sv", int'(sv[0]), 1);
    chk("w1_co", int'(co[0]), 1);
    chk("w1_wo", int'(wo[0]), 1);
    en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    en = 1'b0; step();
    chk("w5_sv", int'(sv[0]), 1);
    chk("w5_co", int'(co[0]), 5);
    chk("w5_wo", int'(wo[0]), 5);
    rc = 2'd3; step();
    chk("oor_co", int'(co[3]), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      obs = 4'($urandom);
      if ($urandom_range(0, 7) == 0) en = ~en;
      cr  = ($urandom_range(0, 63) == 0);
      rc  = 2'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
